// File: rtl/opto_pkg.sv
// Shared constants for the code-disc decoder and the downstream speed stage.
// FSM state encodings plus the default build-time sizes.
package opto_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int OPTO_TOOTH_NUM   = 100;
    localparam int OPTO_TIMEOUT_CLK = 2000000;
    localparam int OPTO_PERIOD_W    = 24;
    localparam int OPTO_IDX_W       = 8;

endpackage

// File: rtl/opto_period_meter.sv
// Rising-edge detect, saturating tooth-period counter, period/prev latches,
// stop timeout and the 1.5x missing-tooth (zero mark) comparison.
module opto_period_meter
    import opto_pkg::*;
#(
    parameter int PERIOD_W    = OPTO_PERIOD_W,
    parameter int TIMEOUT_CLK = OPTO_TIMEOUT_CLK
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_opto_signal,
    input  logic                i_armed,
    output logic                o_edge,
    output logic                o_zero_hit,
    output logic                o_timeout,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_period_vld
);

    logic                sig_d1_q;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] prev_q, prev_d;
    logic                vld_q, vld_d;
    logic [1:0]          done_q, done_d;
    logic [PERIOD_W:0]   cur_ext, thresh;

    assign o_edge    = i_opto_signal & ~sig_d1_q;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1);
    // One extra bit so prev + prev/2 and the current period never wrap.
    assign cur_ext    = {1'b0, cnt_q} + (PERIOD_W+1)'(1);
    assign thresh     = {1'b0, prev_q} + {2'b00, prev_q[PERIOD_W-1:1]};
    assign o_zero_hit = o_edge & done_q[1] & (cur_ext >= thresh);
    assign o_timeout  = ~o_edge & (cnt_q == PERIOD_W'(TIMEOUT_CLK - 1));

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        cnt_d    = cnt_inc;
        period_d = period_q;
        prev_d   = prev_q;
        vld_d    = 1'b0;
        done_d   = done_q;
        if (o_edge) begin
            cnt_d = '0;
            if (i_armed) begin
                period_d = cnt_inc;
                prev_d   = period_q;
                vld_d    = 1'b1;
                if (!done_q[1]) done_d = done_q + 2'd1;
            end else begin
                done_d = '0;
            end
        end else if (o_timeout) begin
            done_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            sig_d1_q <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            prev_q   <= '0;
            vld_q    <= 1'b0;
            done_q   <= '0;
        end else begin
            sig_d1_q <= i_opto_signal;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            prev_q   <= prev_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
        end
    end

    assign o_period     = period_q;
    assign o_period_vld = vld_q;

endmodule

// File: rtl/opto_code_disc_decoder.sv
// Code-disc decoder: zero-mark lock FSM, tooth index, strobes and stop status.
// Optional tooth-count check enabled by defining OPTO_TOOTH_CHECK_EN.
module opto_code_disc_decoder
    import opto_pkg::*;
#(
    parameter int TOOTH_NUM   = OPTO_TOOTH_NUM,
    parameter int PERIOD_W    = OPTO_PERIOD_W,
    parameter int TIMEOUT_CLK = OPTO_TIMEOUT_CLK,
    parameter int IDX_W       = OPTO_IDX_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_opto_signal,
    output logic                o_tooth_pulse,
    output logic                o_zero_pulse,
    output logic [IDX_W-1:0]    o_tooth_idx,
    output logic [PERIOD_W-1:0] o_period,
    output logic                o_period_vld,
    output logic                o_locked,
    output logic                o_motor_stop,
    output logic                o_tooth_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOOTH_NUM - 1);

    logic             edge_det, zero_hit, timeout;
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tooth_pulse_q, tooth_pulse_d;
    logic             zero_pulse_q, zero_pulse_d;
    logic             locked_q, locked_d;
    logic             stop_q, stop_d;
`ifdef OPTO_TOOTH_CHECK_EN
    logic             err_q, err_d, count_err;
`endif

    opto_period_meter #(
        .PERIOD_W    (PERIOD_W),
        .TIMEOUT_CLK (TIMEOUT_CLK)
    ) u_meter (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_opto_signal (i_opto_signal),
        .i_armed       (state_q != ST_IDLE),
        .o_edge        (edge_det),
        .o_zero_hit    (zero_hit),
        .o_timeout     (timeout),
        .o_period      (o_period),
        .o_period_vld  (o_period_vld)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        locked_d      = locked_q;
        stop_d        = stop_q;
        tooth_pulse_d = 1'b0;
        zero_pulse_d  = 1'b0;
`ifdef OPTO_TOOTH_CHECK_EN
        err_d     = err_q;
        count_err = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    state_d = ST_SYNC;
                    stop_d  = 1'b0;
                end
            end
            ST_SYNC: begin
                if (zero_hit) begin
                    state_d       = ST_LOCKED;
                    idx_d         = '0;
                    zero_pulse_d  = 1'b1;
                    tooth_pulse_d = 1'b1;
                    locked_d      = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (edge_det) begin
                    tooth_pulse_d = 1'b1;
                    if (zero_hit) begin
                        idx_d        = '0;
                        zero_pulse_d = 1'b1;
`ifdef OPTO_TOOTH_CHECK_EN
                        count_err    = (idx_q != LAST_IDX);
`endif
                    end else begin
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
`ifdef OPTO_TOOTH_CHECK_EN
                        count_err = (idx_q == LAST_IDX);
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef OPTO_TOOTH_CHECK_EN
        // Premature or missed zero: drop lock and hunt for the next gap.
        if (count_err) begin
            err_d    = 1'b1;
            state_d  = ST_SYNC;
            locked_d = 1'b0;
        end
`endif
        if (timeout) begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            stop_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            tooth_pulse_q <= 1'b0;
            zero_pulse_q  <= 1'b0;
            locked_q      <= 1'b0;
            stop_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tooth_pulse_q <= tooth_pulse_d;
            zero_pulse_q  <= zero_pulse_d;
            locked_q      <= locked_d;
            stop_q        <= stop_d;
        end
    end

`ifdef OPTO_TOOTH_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign o_tooth_err = err_q;
`else
    assign o_tooth_err = 1'b0;
`endif

    assign o_tooth_pulse = tooth_pulse_q;
    assign o_zero_pulse  = zero_pulse_q;
    assign o_tooth_idx   = idx_q;
    assign o_locked      = locked_q;
    assign o_motor_stop  = stop_q;

endmodule

// File: tb/tb_opto_code_disc_decoder.sv
// Scoreboard bench for opto_code_disc_decoder (TOOTH_NUM=8, TIMEOUT_CLK=1000).
// Stimulus queues expected per-edge responses; a monitor checks them on o_period_vld.
module tb_opto_code_disc_decoder;

    localparam int TN = 8;
    localparam int PW = 24;
    localparam int TO = 1000;
    localparam int IW = 8;
    localparam int HI = 10;
`ifdef OPTO_TOOTH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [PW-1:0] period;
        logic          tooth;
        logic          zero;
        logic [IW-1:0] idx;
        logic          locked;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig = 1'b0;
    logic          o_tooth_pulse, o_zero_pulse, o_period_vld, o_locked, o_motor_stop, o_tooth_err;
    logic [IW-1:0] o_tooth_idx;
    logic [PW-1:0] o_period;

    int ramp_p[7] = '{50, 60, 60, 60, 50, 50, 50};
    int bnd_p[7]  = '{50, 50, 74, 50, 50, 50, 50};

    opto_code_disc_decoder #(
        .TOOTH_NUM   (TN),
        .PERIOD_W    (PW),
        .TIMEOUT_CLK (TO),
        .IDX_W       (IW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_opto_signal (sig),
        .o_tooth_pulse (o_tooth_pulse),
        .o_zero_pulse  (o_zero_pulse),
        .o_tooth_idx   (o_tooth_idx),
        .o_period      (o_period),
        .o_period_vld  (o_period_vld),
        .o_locked      (o_locked),
        .o_motor_stop  (o_motor_stop),
        .o_tooth_err   (o_tooth_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".tooth_pulse"}, 32'(o_tooth_pulse), 0);
        check({tag, ".zero_pulse"},  32'(o_zero_pulse),  0);
        check({tag, ".idx"},         32'(o_tooth_idx),   0);
        check({tag, ".period"},      32'(o_period),      0);
        check({tag, ".period_vld"},  32'(o_period_vld),  0);
        check({tag, ".locked"},      32'(o_locked),      0);
        check({tag, ".motor_stop"},  32'(o_motor_stop),  1);
        check({tag, ".tooth_err"},   32'(o_tooth_err),   0);
    endtask

    // Rising edge 'gap' clocks after the previous one; queue the expected response if any.
    task automatic tooth(input int gap, input bit vld, input int per, input bit tp, input bit zp,
                         input int idx, input bit lk, input bit er);
        sig = 1'b0;
        repeat (gap - HI) @(negedge clk);
        sig = 1'b1;
        if (vld) begin
            exp_t e;
            e.period = per[PW-1:0];
            e.tooth  = tp;
            e.zero   = zp;
            e.idx    = idx[IW-1:0];
            e.locked = lk;
            e.err    = er;
            sb_q.push_back(e);
        end
        repeat (HI) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_period_vld) begin
                if (sb_q.size() == 0) begin
                    check("vld_unexpected", 32'(o_period_vld), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("period",      32'(o_period),      32'(mon_e.period));
                    check("tooth_pulse", 32'(o_tooth_pulse), 32'(mon_e.tooth));
                    check("zero_pulse",  32'(o_zero_pulse),  32'(mon_e.zero));
                    check("tooth_idx",   32'(o_tooth_idx),   32'(mon_e.idx));
                    check("locked",      32'(o_locked),      32'(mon_e.locked));
                    check("tooth_err",   32'(o_tooth_err),   32'(mon_e.err));
                end
            end else if (o_tooth_pulse || o_zero_pulse) begin
                check("stray_pulse", {30'b0, o_zero_pulse, o_tooth_pulse}, 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        expect_reset("in_reset");
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        expect_reset("idle_low");

        // Acquire lock: IDLE edge, three steady teeth, then the zero gap.
        tooth(20, 1'b0, 0, 0, 0, 0, 0, 0);
        check("leave_idle.motor_stop", 32'(o_motor_stop), 0);
        check("leave_idle.locked",     32'(o_locked),     0);
        for (int i = 0; i < 3; i++) tooth(50, 1'b1, 50, 0, 0, 0, 0, 0);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, 0);
        for (int i = 1; i < TN; i++) tooth(50, 1'b1, 50, 1, 0, i, 1, 0);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, 0);

        // 1.2x ramp must not look like a zero mark.
        for (int i = 0; i < 7; i++) tooth(ramp_p[i], 1'b1, ramp_p[i], 1, 0, i + 1, 1, 0);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, 0);

        // 74 clk stays a tooth, 75 clk is exactly 1.5x and is the zero.
        for (int i = 0; i < 7; i++) tooth(bnd_p[i], 1'b1, bnd_p[i], 1, 0, i + 1, 1, 0);
        tooth(75, 1'b1, 75, 1, 1, 0, 1, 0);

        // Premature zero after five teeth.
        for (int i = 1; i <= 5; i++) tooth(50, 1'b1, 50, 1, 0, i, 1, 0);
        tooth(100, 1'b1, 100, 1, 1, 0, !CHK, CHK);
        for (int i = 1; i < TN; i++) tooth(50, 1'b1, 50, !CHK, 0, CHK ? 0 : i, !CHK, CHK);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, CHK);

        // Stop timeout: index holds, lock drops exactly TIMEOUT_CLK clocks after the last edge.
        for (int i = 1; i <= 3; i++) tooth(50, 1'b1, 50, 1, 0, i, 1, CHK);
        sig = 1'b0;
        repeat (TO - HI) @(negedge clk);
        check("pre_timeout.locked",     32'(o_locked),     1);
        check("pre_timeout.motor_stop", 32'(o_motor_stop), 0);
        @(negedge clk);
        check("timeout.locked",     32'(o_locked),     0);
        check("timeout.motor_stop", 32'(o_motor_stop), 1);
        check("timeout.idx_hold",   32'(o_tooth_idx),  3);

        // Restart: long first period must not lock; relock only on the next gap.
        tooth(20, 1'b0, 0, 0, 0, 0, 0, 0);
        check("restart.motor_stop", 32'(o_motor_stop), 0);
        tooth(100, 1'b1, 100, 0, 0, 3, 0, CHK);
        tooth(50,  1'b1, 50,  0, 0, 3, 0, CHK);
        tooth(50,  1'b1, 50,  0, 0, 3, 0, CHK);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, CHK);

        // Asynchronous reset mid-revolution.
        tooth(50, 1'b1, 50, 1, 0, 1, 1, CHK);
        tooth(50, 1'b1, 50, 1, 0, 2, 1, CHK);
        sig   = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tooth(20, 1'b0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tooth(50, 1'b1, 50, 0, 0, 0, 0, 0);
        tooth(100, 1'b1, 100, 1, 1, 0, 1, 0);
        tooth(50, 1'b1, 50, 1, 0, 1, 1, 0);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
